// File: rtl/ddr_port_scheduler_pkg.sv
// Shared types and constants for the DDR port scheduler (icache/dcache arbitration onto one DDR port).
package ddr_sched_pkg;

  localparam int ADDR_W_DEF  = 64;
  localparam int LINE_W_DEF  = 512;
  localparam int TIMEOUT_DEF = 1024;
  localparam int OPTYPE_W    = 2;

  localparam logic [OPTYPE_W-1:0] OPTYPE_READ  = 2'b00;
  localparam logic [OPTYPE_W-1:0] OPTYPE_WRITE = 2'b01;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {OWN_IC, OWN_DC} owner_e;

  // Encodings other than OPTYPE_WRITE are treated as reads.
  function automatic logic is_write(input logic [OPTYPE_W-1:0] op);
    return op == OPTYPE_WRITE;
  endfunction

endpackage

// File: rtl/ddr_port_scheduler_if.sv
// Bundle of the icache, dcache and DDR-pin signals; slave = scheduler side, master = clients/DDR side.
interface ddr_port_scheduler_if #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 512
);
  import ddr_sched_pkg::*;

  logic                ic_req_valid;
  logic                ic_req_ready;
  logic [ADDR_W-1:0]   ic_req_index;
  logic [LINE_W-1:0]   ic_resp_data;
  logic                ic_resp_done;

  logic                dc_req_valid;
  logic                dc_req_ready;
  logic [ADDR_W-1:0]   dc_req_index;
  logic [OPTYPE_W-1:0] dc_req_optype;
  logic [LINE_W-1:0]   dc_req_wdata;
  logic [LINE_W-1:0]   dc_req_wmask;
  logic [LINE_W-1:0]   dc_resp_data;
  logic                dc_resp_done;

  logic                ddr_chip_enable;
  logic [ADDR_W-1:0]   ddr_index;
  logic                ddr_write_enable;
  logic                ddr_burst_mode;
  logic [LINE_W-1:0]   ddr_write_mask;
  logic [LINE_W-1:0]   ddr_write_data;
  logic [LINE_W-1:0]   ddr_read_data;
  logic                ddr_operation_done;
  logic                ddr_ready;

  modport slave (
    input  ic_req_valid, ic_req_index,
    output ic_req_ready, ic_resp_data, ic_resp_done,
    input  dc_req_valid, dc_req_index, dc_req_optype, dc_req_wdata, dc_req_wmask,
    output dc_req_ready, dc_resp_data, dc_resp_done,
    output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    output ddr_write_mask, ddr_write_data,
    input  ddr_read_data, ddr_operation_done, ddr_ready
  );

  modport master (
    output ic_req_valid, ic_req_index,
    input  ic_req_ready, ic_resp_data, ic_resp_done,
    output dc_req_valid, dc_req_index, dc_req_optype, dc_req_wdata, dc_req_wmask,
    input  dc_req_ready, dc_resp_data, dc_resp_done,
    input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
    input  ddr_write_mask, ddr_write_data,
    output ddr_read_data, ddr_operation_done, ddr_ready
  );

endinterface

// File: rtl/ddr_port_scheduler_rr_arb2.sv
// Two-way round-robin pick; the requester served last loses a tie. Pointer starts favouring dcache.
module rr_arb2
  import ddr_sched_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ic_req_i,
  input  logic   dc_req_i,
  input  logic   update_i,
  input  owner_e served_i,
  output logic   ic_pick_o,
  output logic   dc_pick_o
);

  owner_e last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_IC;
    end else if (update_i) begin
      last_q <= served_i;
    end
  end

  always_comb begin
    ic_pick_o = 1'b0;
    dc_pick_o = 1'b0;
    if (ic_req_i && dc_req_i) begin
      if (last_q == OWN_DC) ic_pick_o = 1'b1;
      else                  dc_pick_o = 1'b1;
    end else begin
      ic_pick_o = ic_req_i;
      dc_pick_o = dc_req_i;
    end
  end

endmodule

// File: rtl/ddr_port_scheduler.sv
// Shares one DDR port between icache refills and dcache accesses: one outstanding command,
// registered command fields, response routed to the owner, icache flush-drop and a completion watchdog.
module ddr_port_scheduler
  import ddr_sched_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int LINE_W         = LINE_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 icache_flush_i,
  ddr_port_scheduler_if.slave  bus,
  output logic                 err_timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  owner_e              owner_q;
  logic [ADDR_W-1:0]   index_q;
  logic                we_q, burst_q, ce_q;
  logic [LINE_W-1:0]   wmask_q, wdata_q, ic_data_q, dc_data_q;
  logic                drop_q, err_q;
  logic [CNT_W-1:0]    wdog_q;

  logic                ic_pick, dc_pick, grant_en, accept, resp_phase;
  logic                wdog_expired, complete;
  logic [LINE_W-1:0]   resp_line;

  assign grant_en   = (state_q == IDLE) && bus.ddr_ready;
  assign resp_phase = (state_q == RESP);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .ic_req_i  (bus.ic_req_valid && !icache_flush_i),
    .dc_req_i  (bus.dc_req_valid),
    .update_i  (resp_phase),
    .served_i  (owner_q),
    .ic_pick_o (ic_pick),
    .dc_pick_o (dc_pick)
  );

  assign bus.ic_req_ready = grant_en && ic_pick;
  assign bus.dc_req_ready = grant_en && dc_pick;
  assign accept           = bus.ic_req_ready || bus.dc_req_ready;
  assign wdog_expired     = (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // A real completion beats a simultaneous watchdog expiry; writes and timeouts return zero.
  assign resp_line = (bus.ddr_operation_done && !we_q) ? bus.ddr_read_data : '0;

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (bus.ddr_operation_done || wdog_expired) begin
          state_d  = RESP;
          complete = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IC;
      index_q   <= '0;
      we_q      <= 1'b0;
      burst_q   <= 1'b0;
      ce_q      <= 1'b0;
      wmask_q   <= '0;
      wdata_q   <= '0;
      ic_data_q <= '0;
      dc_data_q <= '0;
      drop_q    <= 1'b0;
      err_q     <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q <= state_d;
      ce_q    <= accept;
      if (accept) begin
        owner_q <= ic_pick ? OWN_IC : OWN_DC;
        index_q <= ic_pick ? bus.ic_req_index : bus.dc_req_index;
        we_q    <= dc_pick && is_write(bus.dc_req_optype);
        burst_q <= ic_pick;
        wmask_q <= ic_pick ? '0 : bus.dc_req_wmask;
        wdata_q <= ic_pick ? '0 : bus.dc_req_wdata;
        drop_q  <= 1'b0;
        wdog_q  <= '0;
      end
      if (icache_flush_i && (owner_q == OWN_IC) && (state_q != IDLE)) drop_q <= 1'b1;
      if (state_q == WAIT) wdog_q <= wdog_q + CNT_W'(1);
      if (complete) begin
        if (owner_q == OWN_IC) ic_data_q <= resp_line;
        else                   dc_data_q <= resp_line;
        if (!bus.ddr_operation_done) err_q <= 1'b1;
      end
    end
  end

  assign bus.ic_resp_done     = resp_phase && (owner_q == OWN_IC) && !drop_q && !icache_flush_i;
  assign bus.dc_resp_done     = resp_phase && (owner_q == OWN_DC);
  assign bus.ic_resp_data     = ic_data_q;
  assign bus.dc_resp_data     = dc_data_q;
  assign bus.ddr_chip_enable  = ce_q;
  assign bus.ddr_index        = index_q;
  assign bus.ddr_write_enable = we_q;
  assign bus.ddr_burst_mode   = burst_q;
  assign bus.ddr_write_mask   = wmask_q;
  assign bus.ddr_write_data   = wdata_q;
  assign err_timeout_o        = err_q;

endmodule

// File: tb/tb_ddr_port_scheduler.sv
// Randomized directed bench for ddr_port_scheduler against a transaction-level reference model.
module tb_ddr_port_scheduler;
  import ddr_sched_pkg::*;

  localparam int AW = 64;
  localparam int LW = 512;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic icache_flush = 1'b0;
  logic err_timeout;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // reference model state: who was served last, and what each response register should hold
  bit            last_ic  = 1'b1;
  logic [LW-1:0] ic_model = '0;
  logic [LW-1:0] dc_model = '0;
  bit            ic_known = 1'b1;

  ddr_port_scheduler_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  ddr_port_scheduler #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_flush_i (icache_flush),
    .bus            (bus),
    .err_timeout_o  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return {32'($urandom), 32'($urandom)};
  endfunction

  // One complete transaction, starting and ending at a negedge in IDLE. lat = cycles from strobe
  // to DDR done (0 = never, watchdog fires). hold_dc keeps a dcache request pending while busy.
  task automatic do_txn(input bit ic_v, input bit dc_v, input logic [AW-1:0] ic_idx,
                        input logic [AW-1:0] dc_idx, input logic [1:0] op,
                        input logic [LW-1:0] wd, input logic [LW-1:0] wm,
                        input int lat, input bit flush_wait, input bit hold_dc);
    bit            win_ic, exp_we, timed_out;
    logic [LW-1:0] rd, exp_line;
    win_ic = ic_v && (!dc_v || !last_ic);
    exp_we = !win_ic && (op == 2'b01);
    rd     = rand_line();
    bus.ic_req_valid  = ic_v;
    bus.ic_req_index  = ic_idx;
    bus.dc_req_valid  = dc_v;
    bus.dc_req_index  = dc_idx;
    bus.dc_req_optype = op;
    bus.dc_req_wdata  = wd;
    bus.dc_req_wmask  = wm;
    #1;
    check("ic_ready", bus.ic_req_ready, win_ic);
    check("dc_ready", bus.dc_req_ready, !win_ic);
    @(negedge clk);
    bus.ic_req_valid = 1'b0;
    bus.dc_req_valid = hold_dc;
    check("strobe", bus.ddr_chip_enable, 1'b1);
    check("cmd_index", bus.ddr_index, win_ic ? ic_idx : dc_idx);
    check("cmd_we", bus.ddr_write_enable, exp_we);
    check("cmd_burst", bus.ddr_burst_mode, win_ic);
    check("cmd_mask", bus.ddr_write_mask, win_ic ? '0 : wm);
    check("cmd_data", bus.ddr_write_data, win_ic ? '0 : wd);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      icache_flush = flush_wait && (c == 1);
      check("wait_strobe", bus.ddr_chip_enable, 1'b0);
      check("wait_done", {bus.ic_resp_done, bus.dc_resp_done}, 2'b00);
      if (hold_dc) check("busy_dc_ready", bus.dc_req_ready, 1'b0);
      if (lat == c) begin
        bus.ddr_operation_done = 1'b1;
        bus.ddr_read_data      = rd;
        break;
      end
    end
    @(negedge clk);
    bus.ddr_operation_done = 1'b0;
    bus.ddr_read_data      = rand_line();
    icache_flush           = 1'b0;
    timed_out = (lat == 0);
    exp_line  = (timed_out || exp_we) ? '0 : rd;
    check("ic_done", bus.ic_resp_done, win_ic && !flush_wait);
    check("dc_done", bus.dc_resp_done, !win_ic);
    if (hold_dc) check("resp_dc_ready", bus.dc_req_ready, 1'b0);
    if (win_ic) begin
      if (!flush_wait) begin
        check("ic_data", bus.ic_resp_data, exp_line);
        ic_model = exp_line;
        ic_known = 1'b1;
      end else begin
        ic_known = 1'b0;
      end
      check("dc_hold", bus.dc_resp_data, dc_model);
    end else begin
      check("dc_data", bus.dc_resp_data, exp_line);
      dc_model = exp_line;
      if (ic_known) check("ic_hold", bus.ic_resp_data, ic_model);
    end
    if (timed_out) check("err_set", err_timeout, 1'b1);
    last_ic = win_ic;
    @(negedge clk);
    bus.dc_req_valid = 1'b0;
    check("done_clear", {bus.ic_resp_done, bus.dc_resp_done}, 2'b00);
    $display("txn owner=%s lat=%0d flush=%0b we=%0b", win_ic ? "ic" : "dc", lat, flush_wait, exp_we);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int r;
    bus.ic_req_valid = 0; bus.ic_req_index = '0;
    bus.dc_req_valid = 0; bus.dc_req_index = '0; bus.dc_req_optype = '0;
    bus.dc_req_wdata = '0; bus.dc_req_wmask = '0;
    bus.ddr_read_data = '0; bus.ddr_operation_done = 0; bus.ddr_ready = 1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_strobe", bus.ddr_chip_enable, 1'b0);
    check("rst_done", {bus.ic_resp_done, bus.dc_resp_done}, 2'b00);
    check("rst_ic_data", bus.ic_resp_data, '0);
    check("rst_dc_data", bus.dc_resp_data, '0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_index", bus.ddr_index, '0);
    rst = 1'b0;
    @(negedge clk);

    // DDR not ready: nobody is accepted, no strobe
    bus.ddr_ready = 1'b0; bus.ic_req_valid = 1'b1; bus.dc_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("nrdy_ready", {bus.ic_req_ready, bus.dc_req_ready}, 2'b00);
      check("nrdy_strobe", bus.ddr_chip_enable, 1'b0);
      @(negedge clk);
    end
    bus.ddr_ready = 1'b1;
    do_txn(1, 1, rand_addr(), rand_addr(), 2'b00, rand_line(), rand_line(), 2, 0, 0);

    // icache is not granted while flush is asserted
    icache_flush = 1'b1; bus.ic_req_valid = 1'b1;
    #1;
    check("flush_no_grant", bus.ic_req_ready, 1'b0);
    icache_flush = 1'b0; bus.ic_req_valid = 1'b0;
    @(negedge clk);

    // directed icache refill and dcache full-line write
    do_txn(1, 0, 64'h8000_0040, '0, 2'b00, '0, '0, 3, 0, 0);
    do_txn(0, 1, '0, 64'h1000, 2'b01, {64{8'hA5}}, '1, 4, 0, 0);

    // both requesting back to back: grants must alternate
    for (int i = 0; i < 6; i++)
      do_txn(1, 1, rand_addr(), rand_addr(), 2'($urandom_range(0, 3)), rand_line(), rand_line(),
             $urandom_range(1, 6), 0, 0);

    // random mix
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(1, 3);
      do_txn(r[0], r[1], rand_addr(), rand_addr(), 2'($urandom_range(0, 3)), rand_line(),
             rand_line(), $urandom_range(1, 6), 0, 0);
    end

    // flush during icache WAIT: response dropped, pending dcache served only afterwards
    do_txn(1, 0, rand_addr(), '0, 2'b00, '0, '0, 4, 1, 1);
    do_txn(0, 1, '0, rand_addr(), 2'b00, rand_line(), rand_line(), 2, 0, 0);

    // watchdog: no DDR done, forced completion with zero data, sticky error
    do_txn(0, 1, '0, rand_addr(), 2'b00, rand_line(), rand_line(), 0, 0, 0);
    bus.ddr_operation_done = 1'b1; bus.ddr_read_data = rand_line();
    @(negedge clk);
    bus.ddr_operation_done = 1'b0;
    check("late_done_ignored", {bus.ic_resp_done, bus.dc_resp_done}, 2'b00);
    check("late_done_strobe", bus.ddr_chip_enable, 1'b0);
    @(negedge clk);
    do_txn(1, 0, rand_addr(), '0, 2'b00, '0, '0, 1, 0, 0);
    check("err_sticky", err_timeout, 1'b1);

    // reset in the middle of a dcache transaction: aborted, no completion
    bus.dc_req_valid = 1'b1; bus.dc_req_index = rand_addr(); bus.dc_req_optype = 2'b00;
    @(negedge clk);
    bus.dc_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_err", err_timeout, 1'b0);
    check("midrst_strobe", bus.ddr_chip_enable, 1'b0);
    check("midrst_dc_data", bus.dc_resp_data, '0);
    @(negedge clk);
    rst = 1'b0;
    bus.ddr_operation_done = 1'b1; bus.ddr_read_data = rand_line();
    @(negedge clk);
    bus.ddr_operation_done = 1'b0;
    check("midrst_no_done", {bus.ic_resp_done, bus.dc_resp_done}, 2'b00);
    last_ic = 1'b1; ic_model = '0; dc_model = '0; ic_known = 1'b1;
    do_txn(1, 1, rand_addr(), rand_addr(), 2'b01, rand_line(), rand_line(), 3, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
